// File: rtl/mem_pkg.sv
// mem_pkg: byte-lane steering function and clear FSM state type shared by dp_byte_ram
package mem_pkg;
  localparam int MAX_NB = 32;
  localparam int MAX_W = 8 * MAX_NB;
  typedef enum logic {CLEAR, RUN} clr_state_t;
  function automatic logic [MAX_W-1:0] steer(input logic [MAX_NB-1:0] sel, input logic [MAX_W-1:0] d, input logic [MAX_W-1:0] old);
    logic pair;
    logic [7:0] lane;
    steer = old;
    pair = 1'b0;
    for (int k = 0; k < MAX_NB / 2; k++) pair |= sel == (MAX_NB'(3) << (2 * k));
    for (int j = 0; j < MAX_NB; j++) begin
      lane = $onehot(sel) ? d[7:0] : pair ? d[8 * (j % 2) +: 8] : d[8 * j +: 8];
      if (sel[j]) steer[8 * j +: 8] = lane;
    end
  endfunction
endpackage

// File: rtl/dp_ram_core.sv
// dp_ram_core: byte-enabled RAM, one write/read port plus one read port, synchronous reads
module dp_ram_core #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic                    re,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   q_a,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  output logic [DATA_WIDTH-1:0]   q_b
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    for (int i = 0; i < DATA_WIDTH / 8; i++)
      if (we && wmask[i]) mem[addr_a][8 * i +: 8] <= wdata[8 * i +: 8];
  always_ff @(posedge clk) begin
    q_b <= rst ? '0 : mem[addr_b];
    if (rst) q_a <= '0;
    else if (re) q_a <= mem[addr_a];
  end
endmodule

// File: rtl/dp_byte_ram.sv
// dp_byte_ram: byte-lane RAM with write-first display port; define CLEAR_ON_RESET_EN to zero the array after rst
module dp_byte_ram
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   d,
  output logic [DATA_WIDTH-1:0]   q,
  output logic                    q_valid,
  input  logic [ADDR_WIDTH-1:0]   dispAddr,
  output logic [DATA_WIDTH-1:0]   dispColor,
  output logic                    busy
);
  localparam int NB = DATA_WIDTH / 8;
  logic clr, w_en, r_en;
  logic [ADDR_WIDTH-1:0] cnt, w_addr;
  logic [NB-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_data, q_b, byp_data, byp_bits;
`ifdef CLEAR_ON_RESET_EN
  clr_state_t state;
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + ADDR_WIDTH'(1);
      if (&cnt) state <= RUN;
    end
  assign clr = state == CLEAR;
`else
  assign clr = 1'b0;
  assign cnt = '0;
`endif
  assign busy = clr;
  assign w_en = clr | (en & we);
  assign r_en = en & ~we & ~clr;
  assign w_addr = clr ? cnt : addr;
  assign w_mask = clr ? '1 : sel;
  assign w_data = clr ? '0 : DATA_WIDTH'(steer(MAX_NB'(sel), MAX_W'(d), '0));
  // The display port reads the pre-write word; lanes written on the same edge are patched in here.
  always_ff @(posedge clk) begin
    q_valid <= ~rst & r_en;
    byp_data <= w_data;
    for (int i = 0; i < NB; i++)
      byp_bits[8 * i +: 8] <= {8{~rst & w_en & w_mask[i] & (w_addr == dispAddr)}};
  end
  assign dispColor = (q_b & ~byp_bits) | (byp_data & byp_bits);
  dp_ram_core #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_core (
    .clk(clk),
    .rst(rst),
    .we(w_en),
    .re(r_en),
    .wmask(w_mask),
    .addr_a(w_addr),
    .wdata(w_data),
    .q_a(q),
    .addr_b(dispAddr),
    .q_b(q_b)
  );
endmodule

// File: tb/tb_dp_byte_ram.sv
// tb_dp_byte_ram: randomized and directed checks of dp_byte_ram against a word-array model
module tb_dp_byte_ram;
  localparam int AW = 10;
  localparam int N = 1 << AW;
`ifdef CLEAR_ON_RESET_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, we = 1'b0;
  logic [3:0] sel = '0;
  logic [AW-1:0] addr = '0, disp_addr = '0;
  logic [31:0] d = '0;
  logic [31:0] q, dispColor;
  logic q_valid, busy;
  int checks = 0, errors = 0;
  bit chk_on = 1'b0;
  logic [31:0] mm [N];
  bit kn [N];
  logic [31:0] e_q, e_disp;
  logic e_qv, e_qk, e_dk, e_busy;
  int left = 0;
  logic [AW-1:0] caddr = '0;
  always #5 clk = ~clk;
  dp_byte_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .sel(sel), .addr(addr), .d(d),
    .q(q), .q_valid(q_valid), .dispAddr(disp_addr), .dispColor(dispColor), .busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Store rule stated per case: byte replicated, halfword replicated, or lane-aligned word.
  function automatic logic [31:0] mstore(input logic [31:0] old, input logic [3:0] s, input logic [31:0] dd);
    logic [31:0] src, r;
    if ($countones(s) == 1) src = {4{dd[7:0]}};
    else if (s == 4'b0011 || s == 4'b1100) src = {2{dd[15:0]}};
    else src = dd;
    for (int i = 0; i < 4; i++) r[8 * i +: 8] = s[i] ? src[8 * i +: 8] : old[8 * i +: 8];
    return r;
  endfunction
  always @(posedge clk) begin : model
    logic [31:0] nw;
    logic wr, was_busy;
    logic [AW-1:0] wa;
    if (rst) begin
      e_q = '0; e_qv = 1'b0; e_qk = 1'b1; e_disp = '0; e_dk = 1'b1;
      left = CLR ? N : 0;
      caddr = '0;
    end else begin
      was_busy = left > 0; wr = 1'b0; nw = '0; wa = '0;
      if (was_busy) begin
        wr = 1'b1; wa = caddr; caddr++; left--;
      end else if (en && we) begin
        wr = 1'b1; wa = addr; nw = mstore(mm[addr], sel, d);
      end
      e_disp = (wr && wa == disp_addr) ? nw : mm[disp_addr];
      e_dk = (wr && wa == disp_addr) || kn[disp_addr];
      e_qv = !was_busy && en && !we;
      if (e_qv) begin
        e_q = mm[addr]; e_qk = kn[addr];
      end
      if (wr) begin
        mm[wa] = nw; kn[wa] = 1'b1;
      end
    end
    e_busy = left > 0;
  end
  always @(negedge clk)
    if (chk_on) begin
      chk("q_valid", 32'(q_valid), 32'(e_qv));
      if (e_qk) chk("q", q, e_q);
      chk("busy", 32'(busy), 32'(e_busy));
      if (e_dk) chk("dispColor", dispColor, e_disp);
    end
  task automatic drive(input logic e, input logic w, input logic [3:0] s, input logic [AW-1:0] a,
                       input logic [31:0] dd, input logic [AW-1:0] da);
    en = e; we = w; sel = s; addr = a; d = dd; disp_addr = da;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, '0, '0, '0);
  endtask
  task automatic clear_wait(input bit poke, output int n);
    n = 0;
    while (busy && n < 3 * N) begin
      if (poke) drive(1'b1, 1'($urandom), 4'hF, AW'($urandom % 16), $urandom, AW'($urandom % 16));
      else idle();
      n++;
    end
  endtask
  initial begin
    int n, nz;
    logic [AW-1:0] a, da;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_q", q, 32'h0);
    chk("rst_q_valid", 32'(q_valid), 32'h0);
    chk("rst_dispColor", dispColor, 32'h0);
    chk("rst_busy", 32'(busy), 32'(CLR));
    chk_on = 1'b1;
    rst = 1'b0;
    clear_wait(1'b0, n);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 4'hF, AW'(i), $urandom, '0);
    drive(1'b1, 1'b1, 4'hF, 10'd5, 32'hDEADBEEF, '0);
    drive(1'b1, 1'b0, 4'hF, 10'd5, '0, '0);
    chk("full_word_q", q, 32'hDEADBEEF);
    chk("full_word_q_valid", 32'(q_valid), 32'h1);
    chk("model_word5", mm[5], 32'hDEADBEEF);
    drive(1'b1, 1'b1, 4'b0100, 10'd5, 32'h000000AA, '0);
    drive(1'b1, 1'b0, 4'hF, 10'd5, '0, '0);
    chk("byte_lane2", q, 32'hDEAABEEF);
    drive(1'b1, 1'b1, 4'b1100, 10'd5, 32'h00001234, '0);
    drive(1'b1, 1'b0, 4'hF, 10'd5, '0, '0);
    chk("half_upper", q, 32'h1234BEEF);
    chk("model_half_upper", mm[5], 32'h1234BEEF);
    drive(1'b1, 1'b1, 4'hF, 10'd5, 32'h0, '0);
    chk("write_no_q_valid", 32'(q_valid), 32'h0);
    chk("write_holds_q", q, 32'h1234BEEF);
    idle();
    chk("idle_holds_q", q, 32'h1234BEEF);
    drive(1'b1, 1'b1, 4'h0, 10'd5, 32'hFFFFFFFF, '0);
    drive(1'b1, 1'b0, 4'hF, 10'd5, '0, '0);
    chk("sel_zero", q, 32'h0);
    drive(1'b1, 1'b1, 4'hF, 10'd9, 32'h0, '0);
    drive(1'b1, 1'b1, 4'b0110, 10'd9, 32'h11223344, '0);
    drive(1'b1, 1'b0, 4'hF, 10'd9, '0, '0);
    chk("odd_pair_lanes", q, 32'h00223300);
    drive(1'b1, 1'b1, 4'b0011, 10'd9, 32'h0000BEEF, '0);
    drive(1'b1, 1'b0, 4'hF, 10'd9, '0, '0);
    chk("half_lower", q, 32'h0022BEEF);
    drive(1'b1, 1'b1, 4'b1010, 10'd9, 32'hAABBCCDD, '0);
    drive(1'b1, 1'b1, 4'b1000, 10'd8, 32'h00000077, '0);
    drive(1'b1, 1'b0, 4'hF, 10'd9, '0, '0);
    chk("scatter_lanes", q, 32'hAA22CCEF);
    drive(1'b1, 1'b1, 4'hF, 10'd7, 32'h11223344, 10'd7);
    chk("disp_write_first", dispColor, 32'h11223344);
    drive(1'b1, 1'b1, 4'b0001, 10'd7, 32'h00000099, 10'd7);
    chk("disp_merge_first", dispColor, 32'h11223399);
    drive(1'b1, 1'b1, 4'hF, 10'd3, 32'hA5A5A5A5, '0);
    drive(1'b1, 1'b1, 4'b0001, 10'd3, 32'h0000003C, '0);
    drive(1'b1, 1'b0, 4'hF, 10'd3, '0, '0);
    chk("back_to_back", q, 32'hA5A5A53C);
`ifndef CLEAR_ON_RESET_EN
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("rst2_q", q, 32'h0);
    chk("rst2_dispColor", dispColor, 32'h0);
    drive(1'b1, 1'b0, 4'hF, 10'd3, '0, '0);
    chk("persist_across_rst", q, 32'hA5A5A53C);
`endif
    for (int i = 0; i < 600; i++) begin
      a = AW'($urandom % 16);
      da = ($urandom % 2 == 1) ? a : AW'($urandom % 16);
      drive(($urandom % 4) != 0, 1'($urandom), 4'($urandom), a, $urandom, da);
    end
`ifdef CLEAR_ON_RESET_EN
    rst = 1'b1;
    idle();
    rst = 1'b0;
    clear_wait(1'b1, n);
    chk("clear_len", 32'(n), 32'(N));
    nz = 0;
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 1'b0, 4'hF, AW'(i), '0, AW'(N - 1 - i));
      if (q !== 32'h0) nz++;
    end
    chk("clear_all_zero", 32'(nz), 32'h0);
    drive(1'b1, 1'b1, 4'hF, 10'd300, 32'hCAFEF00D, '0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) idle();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    clear_wait(1'b0, n);
    chk("clear_restart_len", 32'(n), 32'(N));
    drive(1'b1, 1'b0, 4'hF, 10'd300, '0, '0);
    chk("clear_restart_word", q, 32'h0);
`endif
    idle();
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dp_byte_ram.md
DP_BYTE_RAM -- requirements
Module: dp_byte_ram

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  ADDR_WIDTH, 10, word-address width; depth = 2**ADDR_WIDTH.
  DATA_WIDTH, 32, word width; multiple of 8 and >= 16; NB = DATA_WIDTH/8 byte lanes.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock.
  rst  in  1  synchronous, active-high reset.
  en  in  1  port A request strobe.
  we  in  1  port A write (1) or read (0); ignored unless en=1.
  sel  in  NB  byte-lane select.
  addr  in  ADDR_WIDTH  port A word address.
  d  in  DATA_WIDTH  write data, low-aligned for sub-word stores.
  q  out  DATA_WIDTH  port A read data.
  q_valid  out  1  q holds the result of a read accepted in the previous cycle.
  dispAddr  in  ADDR_WIDTH  display read address, sampled every cycle.
  dispColor  out  DATA_WIDTH  display read data.
  busy  out  1  clear in progress; port A requests are dropped.

Function
REQ-003 SHALL accept a port A request when en=1 and busy=0; requests with busy=1 SHALL have no effect and SHALL NOT assert q_valid.
REQ-004 SHALL steer write data by sel: one-hot sel[i] writes d[7:0] into lane i; sel with exactly two adjacent bits set at even lane 2k writes d[15:0] into lanes 2k..2k+1; any other nonzero sel writes d lane j into lane j for each set sel[j]; sel=0 writes nothing.
REQ-005 SHALL leave lanes not selected unchanged.
REQ-006 SHALL return read data on q with 1-cycle latency, with q_valid=1 for exactly that cycle; q SHALL hold its value while q_valid=0.
REQ-007 SHALL NOT update q or assert q_valid on a write.
REQ-008 SHALL drive dispColor with the word at dispAddr sampled on the previous edge (1-cycle latency), independent of port A.
REQ-009 SHALL give write-first behaviour on the display port: if a write and the dispAddr sample hit the same address in the same cycle, dispColor SHALL show the merged new word.
REQ-010 SHALL forward a port A write to an immediately following port A read of the same address (back-to-back), returning the merged word.

Reset
REQ-011 SHALL, with rst=1 at a clk edge, set q=0, q_valid=0 and dispColor=0.
REQ-012 SHALL NOT clear the memory array on reset unless CLEAR_ON_RESET_EN is defined.

Configuration
REQ-013 SHALL, with CLEAR_ON_RESET_EN defined, include a clear FSM with states CLEAR and RUN:
  rst forces CLEAR with clear counter = 0 and busy=1.
  Each cycle in CLEAR writes zero to the counter address and increments the counter.
  After writing address 2**ADDR_WIDTH-1, the FSM enters RUN on the next edge and busy=0.
  rst asserted during CLEAR restarts the clear at address 0.
  dispColor reads during CLEAR SHALL return 0 for cleared addresses.
REQ-014 SHALL, without CLEAR_ON_RESET_EN, tie busy to 0 and include no clear logic; array contents SHALL persist across rst.

Structure
REQ-015 SHALL place the lane-steering function (sel, d, old word -> new word) and the FSM state typedef in shared package mem_pkg.
REQ-016 SHALL implement the storage array as one sub-module, dp_ram_core: 1 write/read port plus 1 read port, synchronous reads, per-lane write enable.
REQ-017 SHALL keep steering, forwarding and clear logic in dp_byte_ram; rtl total 120-400 lines.

Verification
REQ-018 Write en=1, we=1, sel=1111, addr=5, d=0xDEADBEEF; then read addr 5 -> next cycle q=0xDEADBEEF, q_valid=1.
REQ-019 Word 5=0xDEADBEEF; write sel=0100, d=0x000000AA -> read gives 0xDEAABEEF; write sel=1100, d=0x00001234 -> read gives 0x1234BEEF.
REQ-020 Write addr 7=0x11223344, dispAddr=7 in the same cycle -> next cycle dispColor=0x11223344.
REQ-021 Write addr 3, then read addr 3 on the very next cycle -> q equals the new merged word.
REQ-022 With CLEAR_ON_RESET_EN: pulse rst -> busy=1 for exactly 2**ADDR_WIDTH cycles; requests during busy are ignored (no q_valid); afterwards every address reads 0.
REQ-023 With CLEAR_ON_RESET_EN: rst re-asserted mid-clear at counter 300 -> clear restarts at 0 and busy lasts a full 2**ADDR_WIDTH cycles from the second reset.
